// File: rtl/ysyx_220053_mc_controller.sv
// Multi-cycle instruction controller for the RV32I/RV64I NPC core.
// Walks each instruction through FETCH -> DECODE -> (MEM) -> WB, drives
// registered datapath/LSU control, and parks in TRAP on ebreak, an illegal
// encoding or an LSU timeout until the next reset.
module ysyx_220053_mc_controller #(
    parameter int XLEN        = 64,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_i,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  mem_size,
    input  logic        mem_ack,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  ext_op,
    output logic [3:0]  alu_op,
    output logic        alu_word,
    output logic [3:0]  branch,
    output logic        rf_wen,
    output logic        pc_wen,
    output logic        halt,
    output logic        illegal,
    output logic        bus_err
);

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MEM, S_WB, S_TRAP} state_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] EXT_I = 3'd0, EXT_U = 3'd1, EXT_S = 3'd2;
    localparam logic [2:0] EXT_B = 3'd3, EXT_J = 3'd4, EXT_R = 3'd5;
    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b1000, ALU_PASSB = 4'b1111;

    localparam bit                IS_RV64     = (XLEN == 64);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    state_t             state_q;
    logic [31:0]        instr_q;
    logic [CNT_W-1:0]   wcnt_q;
    logic               rf_pend_q;
    logic               alu_src_a_q, alu_word_q, mem_req_q, mem_we_q;
    logic [1:0]         alu_src_b_q;
    logic [2:0]         ext_op_q, mem_size_q;
    logic [3:0]         alu_op_q, branch_q;
    logic               rf_wen_q, pc_wen_q, halt_q, illegal_q, bus_err_q;

    // Decoded fields of the latched instruction, registered in DECODE.
    logic               alu_src_a_d, alu_word_d, is_mem_d, is_store_d, rf_pend_d;
    logic               illegal_d, ebreak_d;
    logic [1:0]         alu_src_b_d;
    logic [2:0]         ext_op_d;
    logic [3:0]         alu_op_d, branch_d;

    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic       is_shift, unused_rs1;

    assign opcode     = instr_q[6:0];
    assign rd         = instr_q[11:7];
    assign funct3     = instr_q[14:12];
    assign funct7     = instr_q[31:25];
    assign is_shift   = (funct3 == 3'b001) || (funct3 == 3'b101);
    // rs1 is routed by the datapath directly; the controller never looks at it.
    assign unused_rs1 = ^instr_q[19:15];

    // Combinational decode of the latched instruction word.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        alu_src_a_d = 1'b1;
        alu_src_b_d = 2'd1;
        ext_op_d    = EXT_I;
        alu_op_d    = ALU_ADD;
        alu_word_d  = 1'b0;
        branch_d    = 4'b0000;
        is_mem_d    = 1'b0;
        is_store_d  = 1'b0;
        rf_pend_d   = (rd != 5'd0);
        illegal_d   = 1'b0;
        ebreak_d    = 1'b0;
        unique case (opcode)
            OPC_LUI: begin
                ext_op_d = EXT_U;
                alu_op_d = ALU_PASSB;
            end
            OPC_AUIPC: begin
                alu_src_a_d = 1'b0;
                ext_op_d    = EXT_U;
            end
            OPC_JAL, OPC_JALR: begin
                alu_src_a_d = 1'b0;
                alu_src_b_d = 2'd2;
                ext_op_d    = (opcode == OPC_JAL) ? EXT_J : EXT_I;
                branch_d    = (opcode == OPC_JAL) ? 4'b0001 : 4'b0010;
            end
            OPC_OP_IMM, OPC_OP_IMM32: begin
                alu_word_d = (opcode == OPC_OP_IMM32);
                alu_op_d   = {(funct3 == 3'b101) && instr_q[30], funct3};
                // shamt[5] only exists on RV64 non-word shifts.
                illegal_d  = (is_shift && instr_q[25] && (!IS_RV64 || alu_word_d))
                          || (alu_word_d && !IS_RV64);
            end
            OPC_OP, OPC_OP32: begin
                alu_src_b_d = 2'd0;
                ext_op_d    = EXT_R;
                alu_word_d  = (opcode == OPC_OP32);
                alu_op_d    = {instr_q[30], funct3};
                illegal_d   = ((funct7 != 7'b0000000) && (funct7 != 7'b0100000))
                           || (alu_word_d && !IS_RV64);
            end
            OPC_BRANCH: begin
                alu_src_b_d = 2'd0;
                ext_op_d    = EXT_B;
                alu_op_d    = ALU_SUB;
                branch_d    = {1'b1, funct3};
                rf_pend_d   = 1'b0;
                illegal_d   = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                is_mem_d  = 1'b1;
                illegal_d = (funct3 == 3'b111)
                         || (!IS_RV64 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
            end
            OPC_STORE: begin
                ext_op_d   = EXT_S;
                is_mem_d   = 1'b1;
                is_store_d = 1'b1;
                rf_pend_d  = 1'b0;
                illegal_d  = funct3[2] || (!IS_RV64 && (funct3 == 3'b011));
            end
            OPC_SYSTEM: begin
                // Only ebreak is implemented; every other SYSTEM encoding traps.
                ebreak_d  = (instr_q[31:20] == 12'd1);
                illegal_d = !ebreak_d;
            end
            default: illegal_d = 1'b1;
        endcase
    end

    // Main sequencer with registered control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            instr_q     <= '0;
            wcnt_q      <= '0;
            rf_pend_q   <= 1'b0;
            alu_src_a_q <= 1'b0;
            alu_src_b_q <= 2'd0;
            ext_op_q    <= 3'd0;
            alu_op_q    <= 4'd0;
            alu_word_q  <= 1'b0;
            branch_q    <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= 3'd0;
            rf_wen_q    <= 1'b0;
            pc_wen_q    <= 1'b0;
            halt_q      <= 1'b0;
            illegal_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rf_wen_q <= 1'b0;
            pc_wen_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    if (instr_valid) begin
                        instr_q <= instr_i;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a_q <= alu_src_a_d;
                    alu_src_b_q <= alu_src_b_d;
                    ext_op_q    <= ext_op_d;
                    alu_op_q    <= alu_op_d;
                    alu_word_q  <= alu_word_d;
                    branch_q    <= branch_d;
                    mem_we_q    <= is_store_d;
                    mem_size_q  <= funct3;
                    rf_pend_q   <= rf_pend_d;
                    if (ebreak_d) begin
                        halt_q  <= 1'b1;
                        state_q <= S_TRAP;
                    end else if (illegal_d) begin
                        illegal_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end else if (is_mem_d) begin
                        mem_req_q <= 1'b1;
                        wcnt_q    <= '0;
                        state_q   <= S_MEM;
                    end else begin
                        pc_wen_q <= 1'b1;
                        rf_wen_q <= rf_pend_d;
                        state_q  <= S_WB;
                    end
                end
                S_MEM: begin
                    // An ack on the timeout cycle still completes the access.
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        pc_wen_q  <= 1'b1;
                        if (mem_we_q) begin
                            state_q <= S_FETCH;
                        end else begin
                            rf_wen_q <= rf_pend_q;
                            state_q  <= S_WB;
                        end
                    end else if ((MEM_TIMEOUT != 0) && (wcnt_q == TIMEOUT_CNT)) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_TRAP;
                    end else begin
                        wcnt_q <= wcnt_q + CNT_W'(1);
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign instr_ready = (state_q == S_FETCH);
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_size    = mem_size_q;
    assign alu_src_a   = alu_src_a_q;
    assign alu_src_b   = alu_src_b_q;
    assign ext_op      = ext_op_q;
    assign alu_op      = alu_op_q;
    assign alu_word    = alu_word_q;
    assign branch      = branch_q;
    assign rf_wen      = rf_wen_q;
    assign pc_wen      = pc_wen_q;
    assign halt        = halt_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_ysyx_220053_mc_controller.sv
// Scoreboard bench for the multi-cycle controller (XLEN=32, MEM_TIMEOUT=4).
// Stimulus pushes a hand-computed record per instruction/reset; monitors
// build the observed record and pop/compare.
module tb_ysyx_220053_mc_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_i = 32'd0;
    logic        mem_ack = 1'b0;
    logic        instr_ready, mem_req, mem_we, alu_src_a, alu_word;
    logic        rf_wen, pc_wen, halt, illegal, bus_err;
    logic [2:0]  mem_size, ext_op;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_op, branch;

    always #5 clk = ~clk;

    ysyx_220053_mc_controller #(.XLEN(32), .MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_i(instr_i), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_ack(mem_ack), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_op(ext_op),
        .alu_op(alu_op), .alu_word(alu_word), .branch(branch), .rf_wen(rf_wen),
        .pc_wen(pc_wen), .halt(halt), .illegal(illegal), .bus_err(bus_err)
    );

    localparam logic [1:0] K_RET = 2'd0, K_TRAP = 2'd1, K_RST = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic       a;
        logic [1:0] b;
        logic [2:0] ext;
        logic [3:0] aop;
        logic       word;
        logic [3:0] br;
        logic [7:0] lat;    // cycles to instr_ready; instr_ready itself in reset records
        logic [7:0] req;    // mem_req cycles; mem_req itself in reset records
        logic       we;
        logic [2:0] size;
        logic [3:0] rfc;
        logic [3:0] pcc;
        logic       halt;
        logic       ill;
        logic       berr;
        logic       steady; // trap flags held and instr_ready stayed low
    } rec_t;

    typedef struct { string name; rec_t r; } exp_t;

    exp_t exp_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   ack_delay = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic score(input rec_t act);
        exp_t e;
        check("scoreboard_has_entry", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.name, 64'(act), 64'(e.r));
        end
    endtask

    function automatic rec_t ret(input logic a, input logic [1:0] b, input logic [2:0] ext,
                                 input logic [3:0] aop, input logic [3:0] br, input int lat,
                                 input int req, input logic we, input logic [2:0] size,
                                 input logic rfw);
        rec_t r = '0;
        r.kind = K_RET; r.a = a; r.b = b; r.ext = ext; r.aop = aop; r.br = br;
        r.lat = 8'(lat); r.req = 8'(req); r.we = we; r.size = size;
        r.rfc = {3'd0, rfw}; r.pcc = 4'd1;
        return r;
    endfunction

    function automatic rec_t trp(input logic h, input logic i, input logic be,
                                 input int req, input logic [2:0] size);
        rec_t r = '0;
        r.kind = K_TRAP; r.halt = h; r.ill = i; r.berr = be;
        r.req = 8'(req); r.size = size; r.steady = 1'b1;
        return r;
    endfunction

    function automatic rec_t rst_rec();
        rec_t r = '0;
        r.kind = K_RST; r.lat = 8'd1;
        return r;
    endfunction

    // LSU model: pulses mem_ack on the ack_delay-th cycle of a request (0 = never).
    initial begin : lsu
        int cnt = 0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req === 1'b1) begin
                cnt++;
                if (cnt == ack_delay) mem_ack = 1'b1;
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: tracks one instruction from the accept cycle to its completion or trap.
    logic       m_inflight = 1'b0, m_trapping = 1'b0, m_steady = 1'b0, m_we = 1'b0;
    logic [2:0] m_flags = 3'd0, m_size = 3'd0;
    logic [3:0] m_rfc = 4'd0, m_pcc = 4'd0;
    logic [7:0] m_lat = 8'd0, m_req = 8'd0;
    int         m_tcnt = 0;

    task automatic emit_ret();
        rec_t r = '0;
        r.kind = K_RET; r.a = alu_src_a; r.b = alu_src_b; r.ext = ext_op; r.aop = alu_op;
        r.word = alu_word; r.br = branch; r.lat = m_lat; r.req = m_req; r.we = m_we;
        r.size = m_size; r.rfc = m_rfc; r.pcc = m_pcc;
        score(r);
    endtask

    task automatic emit_trap();
        rec_t r = '0;
        r.kind = K_TRAP; r.req = m_req; r.we = m_we; r.size = m_size;
        r.rfc = m_rfc; r.pcc = m_pcc; {r.halt, r.ill, r.berr} = {halt, illegal, bus_err};
        r.steady = m_steady;
        score(r);
    endtask

    initial begin : clk_monitor
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_inflight = 1'b0;
                m_trapping = 1'b0;
            end else if (m_trapping) begin
                m_tcnt++;
                m_rfc = m_rfc + 4'(rf_wen);
                m_pcc = m_pcc + 4'(pc_wen);
                if (instr_ready || ({halt, illegal, bus_err} !== m_flags)) m_steady = 1'b0;
                if (m_tcnt == 5) begin
                    emit_trap();
                    m_trapping = 1'b0;
                    m_inflight = 1'b0;
                end
            end else if (m_inflight) begin
                m_lat = m_lat + 8'd1;
                m_rfc = m_rfc + 4'(rf_wen);
                m_pcc = m_pcc + 4'(pc_wen);
                if (mem_req) begin
                    m_req  = m_req + 8'd1;
                    m_we   = mem_we;
                    m_size = mem_size;
                end
                if (halt || illegal || bus_err) begin
                    m_trapping = 1'b1;
                    m_tcnt     = 1;
                    m_flags    = {halt, illegal, bus_err};
                    m_steady   = !instr_ready;
                end else if (instr_ready) begin
                    emit_ret();
                    m_inflight = 1'b0;
                end
            end
            if (rst_n && !m_inflight && !m_trapping && instr_ready && instr_valid) begin
                m_inflight = 1'b1;
                m_lat = 8'd0; m_req = 8'd0; m_rfc = 4'd0; m_pcc = 4'd0;
                m_we = 1'b0; m_size = 3'd0;
            end
        end
    end

    // Reset monitor: outputs must clear asynchronously.
    initial begin : rst_monitor
        forever begin
            rec_t r;
            @(negedge rst_n);
            #1;
            r = '0;
            r.kind = K_RST; r.a = alu_src_a; r.b = alu_src_b; r.ext = ext_op; r.aop = alu_op;
            r.word = alu_word; r.br = branch; r.lat = 8'(instr_ready); r.req = 8'(mem_req);
            r.we = mem_we; r.size = mem_size; r.rfc = 4'(rf_wen); r.pcc = 4'(pc_wen);
            {r.halt, r.ill, r.berr} = {halt, illegal, bus_err};
            score(r);
        end
    end

    task automatic do_reset();
        exp_q.push_back('{"reset_state", rst_rec()});
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Present one instruction; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ins, input logic keep_valid);
        int n = 0;
        @(posedge clk);
        #1;
        instr_i = ins;
        instr_valid = 1'b1;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("accept_budget", 64'(n < 20), 64'd1);
        @(posedge clk);
        #1;
        instr_valid = keep_valid;
    endtask

    task automatic wait_done();
        int n = 0;
        @(negedge clk);
        while (!(instr_ready || halt || illegal || bus_err) && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("completion_budget", 64'(n < 40), 64'd1);
    endtask

    task automatic run(input string name, input logic [31:0] ins, input rec_t e, input int delay);
        ack_delay = delay;
        exp_q.push_back('{name, e});
        issue(ins, 1'b0);
        wait_done();
    endtask

    // Trapping instruction: hold instr_valid high to show it is ignored, then reset.
    task automatic run_trap(input string name, input logic [31:0] ins, input rec_t e,
                            input int delay);
        ack_delay = delay;
        exp_q.push_back('{name, e});
        issue(ins, 1'b1);
        wait_done();
        repeat (7) @(negedge clk);
        instr_valid = 1'b0;
        do_reset();
    endtask

    initial begin : stimulus
        exp_q.push_back('{"reset_state", rst_rec()});
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("addi",   32'h00500093, ret(1, 2'd1, 3'd0, 4'b0000, 4'b0000, 3, 0, 0, 3'd0, 1), 0);
        run("srai",   32'h4030D113, ret(1, 2'd1, 3'd0, 4'b1101, 4'b0000, 3, 0, 0, 3'd0, 1), 0);
        run("sub",    32'h40208133, ret(1, 2'd0, 3'd5, 4'b1000, 4'b0000, 3, 0, 0, 3'd0, 1), 0);
        run("lui",    32'h123450B7, ret(1, 2'd1, 3'd1, 4'b1111, 4'b0000, 3, 0, 0, 3'd0, 1), 0);
        run("auipc",  32'h00001117, ret(0, 2'd1, 3'd1, 4'b0000, 4'b0000, 3, 0, 0, 3'd0, 1), 0);
        run("jal",    32'h008000EF, ret(0, 2'd2, 3'd4, 4'b0000, 4'b0001, 3, 0, 0, 3'd0, 1), 0);
        run("jalr",   32'h000080E7, ret(0, 2'd2, 3'd0, 4'b0000, 4'b0010, 3, 0, 0, 3'd0, 1), 0);
        run("lw_ack4", 32'h0000A183, ret(1, 2'd1, 3'd0, 4'b0000, 4'b0000, 7, 4, 0, 3'b010, 1), 4);
        run("sw_ack2", 32'h0030A023, ret(1, 2'd1, 3'd2, 4'b0000, 4'b0000, 4, 2, 1, 3'b010, 0), 2);
        run("beq",    32'h00208463, ret(1, 2'd0, 3'd3, 4'b1000, 4'b1000, 3, 0, 0, 3'd0, 0), 0);
        run("addi_x0", 32'h00000013, ret(1, 2'd1, 3'd0, 4'b0000, 4'b0000, 3, 0, 0, 3'd0, 0), 0);
        run("lw_ack_on_timeout", 32'h0000A183,
            ret(1, 2'd1, 3'd0, 4'b0000, 4'b0000, 8, 5, 0, 3'b010, 1), 5);

        run_trap("lw_timeout", 32'h0000A183, trp(0, 0, 1, 5, 3'b010), 0);
        run_trap("ld_rv32",    32'h0000B183, trp(0, 1, 0, 0, 3'd0), 0);
        run_trap("addiw_rv32", 32'h0010809B, trp(0, 1, 0, 0, 3'd0), 0);
        run_trap("bad_funct7", 32'h02208133, trp(0, 1, 0, 0, 3'd0), 0);
        run_trap("ebreak",     32'h00100073, trp(1, 0, 0, 0, 3'd0), 0);

        // Reset in the middle of a load: only the reset record is expected.
        ack_delay = 0;
        issue(32'h0000A183, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();

        run("addi_after_reset", 32'h00500093,
            ret(1, 2'd1, 3'd0, 4'b0000, 4'b0000, 3, 0, 0, 3'd0, 1), 0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule
